// File: rtl/arb_pkg.sv
// Shared arbiter-slice definitions: client FSM state encoding and default field widths,
// used by arb_client and the arbiter benches.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } arb_state_e;

   localparam int ARB_LEN_W = 3;
   localparam int ARB_TAG_W = 8;

endpackage

// File: rtl/arb_cmd_fifo.sv
// Synchronous command FIFO with DEPTH entries (power of 2, >= 2), full/empty flags and a
// combinational head. Writes while full and reads while empty are ignored.
module arb_cmd_fifo #(
   parameter int W     = 11,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset_l,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic          push_en, pop_en;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   // NOTE: every always_comb output gets a value on every path so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_en);
      rd_ptr_d = rd_ptr_q + AW'(pop_en);
      cnt_d    = cnt_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
   end

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/arb_client.sv
// Per-client requester in front of the shared arbiter: queues burst commands, drives req/last
// and reports ownership. Define ARB_CLIENT_CLR_LAST_EN to force last low whenever req is low.
module arb_client
   import arb_pkg::*;
#(
   parameter int LEN_W = ARB_LEN_W,
   parameter int TAG_W = ARB_TAG_W,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic             req,
   output logic             last,
   input  logic             gnt,
   output logic             own,
   output logic             own_first,
   output logic             own_last,
   output logic [LEN_W-1:0] beat,
   output logic [TAG_W-1:0] own_tag,
   output logic             busy,
   output logic             err_len0
);

   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   cmd_t             push_cmd, head;
   logic             fifo_full, fifo_empty, head_valid;
   logic             pop, load;

   arb_state_e       state_q, state_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             req_q, req_d;
   logic             last_q, last_d;
   logic             err_q, err_d;

   assign push_cmd   = {cmd_len, cmd_tag};
   assign head_valid = !fifo_empty;

   arb_cmd_fifo #(
      .W     ($bits(cmd_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_l (reset_l),
      .push    (cmd_valid),
      .din     (push_cmd),
      .pop     (pop),
      .head    (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign own       = (state_q == WAIT && gnt) || (state_q == BURST);
   assign own_first = (state_q == WAIT) && gnt;
   assign own_last  = own && (count_q == LEN_W'(1));
   assign beat      = len_q - count_q;
   assign own_tag   = tag_q;
   assign req       = req_q;
   assign last      = last_q;
   assign err_len0  = err_q;
   assign cmd_ready = !fifo_full;
   assign busy      = (state_q != IDLE) || !fifo_empty;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      len_d   = len_q;
      tag_d   = tag_q;
      req_d   = req_q;
      last_d  = last_q;
      err_d   = err_q;
      pop     = 1'b0;
      load    = 1'b0;

      case (state_q)
         IDLE: begin
            if (head_valid) begin
               pop = 1'b1;
               if (head.len == '0) err_d = 1'b1;
               else                load  = 1'b1;
            end
         end
         WAIT, BURST: begin
            if (own) begin
               count_d = count_q - LEN_W'(1);
               if (count_q == LEN_W'(1)) begin
                  // Final beat: chain straight into the next command when one is queued.
                  if (head_valid) begin
                     pop = 1'b1;
                     if (head.len == '0) err_d = 1'b1;
                     else                load  = 1'b1;
                  end
                  if (!load) begin
                     req_d   = 1'b0;
                     state_d = IDLE;
`ifdef ARB_CLIENT_CLR_LAST_EN
                     last_d  = 1'b0;
`endif
                  end
               end else begin
                  state_d = BURST;
                  if (count_q == LEN_W'(2)) last_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         count_d = head.len;
         len_d   = head.len;
         tag_d   = head.tag;
         req_d   = 1'b1;
         last_d  = (head.len == LEN_W'(1));
         state_d = WAIT;
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= IDLE;
         count_q <= '0;
         len_q   <= '0;
         tag_q   <= '0;
         req_q   <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         len_q   <= len_d;
         tag_q   <= tag_d;
         req_q   <= req_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_arb_client.sv
// Self-checking bench for arb_client: directed scenarios plus a randomized run checked
// against a transaction-level model of queued bursts.
module tb_arb_client;

   localparam int LEN_W = 3;
   localparam int TAG_W = 8;
   localparam int DEPTH = 2;

`ifdef ARB_CLIENT_CLR_LAST_EN
   localparam logic IDLE_LAST = 1'b0;
`else
   localparam logic IDLE_LAST = 1'b1;
`endif

   logic             clk = 1'b0;
   logic             reset_l;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic [TAG_W-1:0] cmd_tag;
   logic             req, last, gnt;
   logic             own, own_first, own_last;
   logic [LEN_W-1:0] beat;
   logic [TAG_W-1:0] own_tag;
   logic             busy, err_len0;

   logic             gnt_r;
   logic             loop;
   int               chk_cnt  = 0;
   int               pass_cnt = 0;
   logic [TAG_W-1:0] own_log[$];

   assign gnt = loop ? req : gnt_r;

   always #5 clk = ~clk;

   always @(negedge clk) if (own === 1'b1) own_log.push_back(own_tag);

   arb_client #(
      .LEN_W (LEN_W),
      .TAG_W (TAG_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .cmd_tag   (cmd_tag),
      .req       (req),
      .last      (last),
      .gnt       (gnt),
      .own       (own),
      .own_first (own_first),
      .own_last  (own_last),
      .beat      (beat),
      .own_tag   (own_tag),
      .busy      (busy),
      .err_len0  (err_len0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic v, input int len, input int tag);
      cmd_valid = v;
      cmd_len   = LEN_W'(len);
      cmd_tag   = TAG_W'(tag);
   endtask

   task automatic do_reset();
      reset_l = 1'b0;
      drive_cmd(1'b0, 0, 0);
      gnt_r   = 1'b0;
      loop    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_l = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      chk_cnt++;
      if ({req, last, own, busy, err_len0, cmd_ready} !== 6'b000001)
         $display("FAIL reset_state: {req,last,own,busy,err,ready}=%b want 000001",
                  {req, last, own, busy, err_len0, cmd_ready});
      else pass_cnt++;
      step();
   endtask

   task automatic test_single();
      loop = 1'b1;
      drive_cmd(1'b1, 1, 'h11);
      @(negedge clk);
      chk_cnt++;
      if (cmd_ready !== 1'b1) $display("FAIL s1_ready: got %b want 1", cmd_ready);
      else pass_cnt++;
      step();
      drive_cmd(1'b0, 0, 0);
      @(negedge clk);
      chk_cnt++;
      if ({req, busy} !== 2'b01) $display("FAIL s1_t1: {req,busy}=%b want 01", {req, busy});
      else pass_cnt++;
      step();
      @(negedge clk);
      chk_cnt++;
      if ({req, last, own, own_first, own_last, beat, own_tag} !== {5'b11111, 3'd0, 8'h11})
         $display("FAIL s1_t2: {req,last,own,first,olast}=%b beat=%0d tag=%h want 11111 0 11",
                  {req, last, own, own_first, own_last}, beat, own_tag);
      else pass_cnt++;
      step();
      @(negedge clk);
      chk_cnt++;
      if ({req, own, last} !== {2'b00, IDLE_LAST})
         $display("FAIL s1_t3: {req,own,last}=%b want 00%b", {req, own, last}, IDLE_LAST);
      else pass_cnt++;
      step();
   endtask

   task automatic test_grant_delay();
      loop  = 1'b0;
      gnt_r = 1'b0;
      drive_cmd(1'b1, 4, 'h22);
      step();
      drive_cmd(1'b0, 0, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_cnt++;
         if ({req, own, last} !== 3'b100)
            $display("FAIL s2_wait%0d: {req,own,last}=%b want 100", i, {req, own, last});
         else pass_cnt++;
         step();
      end
      gnt_r = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_cnt++;
         if ({own, beat, own_first, own_last, last, own_tag} !==
             {1'b1, LEN_W'(i), i == 0, i == 3, i == 3, 8'h22})
            $display("FAIL s2_beat%0d: own=%b beat=%0d first=%b olast=%b last=%b tag=%h",
                     i, own, beat, own_first, own_last, last, own_tag);
         else pass_cnt++;
         step();
         gnt_r = 1'b0;
      end
      @(negedge clk);
      chk_cnt++;
      if ({req, own, last} !== {2'b00, IDLE_LAST})
         $display("FAIL s2_end: {req,own,last}=%b want 00%b", {req, own, last}, IDLE_LAST);
      else pass_cnt++;
      step();
   endtask

   task automatic test_back_to_back();
      logic [4:0]       exp_v [4];
      logic [TAG_W-1:0] exp_t [4];
      exp_v = '{5'b10110, 5'b11101, 5'b11111, {1'b0, IDLE_LAST, 3'b000}};
      exp_t = '{8'h31, 8'h31, 8'h32, 8'h32};
      loop = 1'b1;
      drive_cmd(1'b1, 2, 'h31);
      step();
      drive_cmd(1'b1, 1, 'h32);
      step();
      drive_cmd(1'b0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_cnt++;
         if ({req, last, own, own_first, own_last} !== exp_v[i] ||
             (i < 3 && own_tag !== exp_t[i]))
            $display("FAIL s3_t%0d: {req,last,own,first,olast}=%b tag=%h want %b tag=%h",
                     i + 2, {req, last, own, own_first, own_last}, own_tag, exp_v[i], exp_t[i]);
         else pass_cnt++;
         step();
      end
   endtask

   task automatic test_full_queue();
      logic [TAG_W-1:0] exp_tags[$];
      int               waited;
      exp_tags = '{8'h41, 8'h41, 8'h42, 8'h42, 8'h43, 8'h43, 8'h44, 8'h44};
      loop  = 1'b0;
      gnt_r = 1'b0;
      own_log.delete();
      for (int i = 0; i < 3; i++) begin
         drive_cmd(1'b1, 2, 'h41 + i);
         @(negedge clk);
         chk_cnt++;
         if (cmd_ready !== 1'b1) $display("FAIL s4_push%0d_ready: got %b want 1", i, cmd_ready);
         else pass_cnt++;
         step();
      end
      drive_cmd(1'b1, 2, 'h44);
      loop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_cnt++;
         if ({cmd_ready, req, busy} !== {i == 2, 2'b11})
            $display("FAIL s4_ready_t%0d: {ready,req,busy}=%b want %b11", i + 3,
                     {cmd_ready, req, busy}, i == 2);
         else pass_cnt++;
         step();
      end
      drive_cmd(1'b0, 0, 0);
      waited = 0;
      while (busy === 1'b1 && waited < 50) begin
         step();
         waited++;
      end
      @(negedge clk);
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL s4_drain: busy=%b after %0d cycles want 0", busy, waited);
      else pass_cnt++;
      chk_cnt++;
      if (own_log != exp_tags)
         $display("FAIL s4_order: %0d owned cycles, got tags %p want %p",
                  own_log.size(), own_log, exp_tags);
      else pass_cnt++;
      step();
   endtask

   task automatic test_zero_len();
      loop = 1'b1;
      drive_cmd(1'b1, 0, 'h51);
      step();
      drive_cmd(1'b1, 1, 'h52);
      @(negedge clk);
      chk_cnt++;
      if (req !== 1'b0) $display("FAIL s5_t1_req: got %b want 0", req);
      else pass_cnt++;
      step();
      drive_cmd(1'b0, 0, 0);
      @(negedge clk);
      chk_cnt++;
      if ({err_len0, req} !== 2'b10) $display("FAIL s5_t2: {err,req}=%b want 10", {err_len0, req});
      else pass_cnt++;
      step();
      @(negedge clk);
      chk_cnt++;
      if ({req, own, own_first, own_last, err_len0, own_tag} !== {5'b11111, 8'h52})
         $display("FAIL s5_t3: {req,own,first,olast,err}=%b tag=%h want 11111 52",
                  {req, own, own_first, own_last, err_len0}, own_tag);
      else pass_cnt++;
      step();
      @(negedge clk);
      chk_cnt++;
      if ({req, busy, err_len0} !== 3'b001)
         $display("FAIL s5_t4: {req,busy,err}=%b want 001", {req, busy, err_len0});
      else pass_cnt++;
      step();
   endtask

   task automatic test_reset_mid_burst();
      loop = 1'b1;
      drive_cmd(1'b1, 4, 'h61);
      step();
      drive_cmd(1'b1, 3, 'h62);
      step();
      drive_cmd(1'b0, 0, 0);
      step();
      step();
      @(negedge clk);
      chk_cnt++;
      if ({own, beat} !== {1'b1, 3'd2})
         $display("FAIL s6_beat2: own=%b beat=%0d want 1 2", own, beat);
      else pass_cnt++;
      #2;
      reset_l = 1'b0;
      #1;
      chk_cnt++;
      if ({req, last, own, busy, err_len0, cmd_ready} !== 6'b000001)
         $display("FAIL s6_async: {req,last,own,busy,err,ready}=%b want 000001",
                  {req, last, own, busy, err_len0, cmd_ready});
      else pass_cnt++;
      @(negedge clk);
      reset_l = 1'b1;
      step();
      step();
      @(negedge clk);
      chk_cnt++;
      if ({req, busy} !== 2'b00) $display("FAIL s6_after: {req,busy}=%b want 00", {req, busy});
      else pass_cnt++;
      step();
   endtask

   // Model: a queue of accepted non-zero commands; each must be owned for len contiguous
   // cycles, in acceptance order, with beats 0..len-1.
   task automatic test_random();
      int               m_len[$];
      int               m_tag[$];
      int               bi;
      int               cyc;
      bit               saw_zero;
      logic [14:0]      got_v, exp_v;
      do_reset();
      bi       = 0;
      cyc      = 0;
      saw_zero = 1'b0;
      while (cyc < 4000 && (cyc < 1500 || m_len.size() != 0 || busy !== 1'b0)) begin
         if (cyc < 1500 && $urandom_range(0, 2) != 0)
            drive_cmd(1'b1, ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 7)),
                      int'($urandom_range(0, 255)));
         else
            drive_cmd(1'b0, 0, 0);
         gnt_r = req && ($urandom_range(0, 2) == 0);
         @(negedge clk);
         if (bi != 0) begin
            chk_cnt++;
            if (own !== 1'b1) $display("FAIL rnd_gap cyc%0d: own=%b mid-burst beat %0d", cyc, own, bi);
            else pass_cnt++;
         end
         if (own === 1'b1) begin
            chk_cnt++;
            if (m_len.size() == 0) begin
               $display("FAIL rnd_own cyc%0d: own=1 with no command pending", cyc);
            end else begin
               got_v = {own_tag, beat, own_first, own_last, last, req};
               exp_v = {TAG_W'(m_tag[0]), LEN_W'(bi), bi == 0, bi == m_len[0] - 1,
                        bi == m_len[0] - 1, 1'b1};
               if (got_v !== exp_v)
                  $display("FAIL rnd_own cyc%0d: {tag,beat,first,olast,last,req}=%h want %h",
                           cyc, got_v, exp_v);
               else pass_cnt++;
               bi++;
               if (bi == m_len[0]) begin
                  void'(m_len.pop_front());
                  void'(m_tag.pop_front());
                  bi = 0;
               end
            end
         end
`ifdef ARB_CLIENT_CLR_LAST_EN
         if (req === 1'b0) begin
            chk_cnt++;
            if (last !== 1'b0) $display("FAIL rnd_last_idle cyc%0d: last=%b want 0", cyc, last);
            else pass_cnt++;
         end
`endif
         if (cmd_valid && cmd_ready === 1'b1) begin
            if (cmd_len == '0) saw_zero = 1'b1;
            else begin
               m_len.push_back(int'(cmd_len));
               m_tag.push_back(int'(cmd_tag));
            end
         end
         step();
         cyc++;
      end
      drive_cmd(1'b0, 0, 0);
      @(negedge clk);
      chk_cnt++;
      if (m_len.size() != 0 || busy !== 1'b0)
         $display("FAIL rnd_drain: %0d commands never owned, busy=%b", m_len.size(), busy);
      else pass_cnt++;
      chk_cnt++;
      if (err_len0 !== saw_zero) $display("FAIL rnd_err: err_len0=%b want %b", err_len0, saw_zero);
      else pass_cnt++;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_grant_delay();
      test_back_to_back();
      test_full_queue();
      test_zero_len();
      test_reset_mid_burst();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
